weight_stream_sequencer: RTL and testbench

//  Sequences one 2-stage-latency, ce-gated parameter ROM (one word per address, DEPTH addresses).

---
 rtl/weight_seq_pkg.sv | 18 +
 rtl/weight_seq_fifo.sv | 49 ++++
 rtl/weight_stream_sequencer.sv | 168 ++++++++++++++++
 tb/tb_weight_stream_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/weight_seq_pkg.sv
// Shared types, defaults and sizing helpers for the weight stream sequencer.
package weight_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  localparam int unsigned FIFO_DEPTH_DEF  = 4;
  localparam int unsigned ROM_LATENCY_DEF = 2;

  // Credit counter must hold FIFO_DEPTH itself, hence depth+1 values.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/weight_seq_fifo.sv
// Synchronous show-ahead FIFO carrying {last, data}; push and pop may coincide at any occupancy.
module weight_seq_fifo
  import weight_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned CW   = credit_width(DEPTH),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/weight_stream_sequencer.sv
// Streams a ce-gated, fixed-latency weight ROM onto a valid/ready bus, cfg_passes sweeps per start.
// Optional stall_cycles counter enabled by defining WEIGHT_SEQ_STALL_CNT_EN.
module weight_stream_sequencer
  import weight_seq_pkg::*;
#(
  parameter int unsigned DWIDTH      = 128,
  parameter int unsigned DEPTH       = 576,
  parameter int unsigned AWIDTH      = $clog2(DEPTH) + 1,
  parameter int unsigned ROM_LATENCY = ROM_LATENCY_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned PASS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] cfg_passes,
  output logic                  busy,
  output logic                  done,
  output logic [AWIDTH-1:0]     rom_addr,
  output logic                  rom_ce,
  input  logic [DWIDTH-1:0]     rom_q,
  output logic [DWIDTH-1:0]     data_out,
  output logic                  data_out_last,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
`ifdef WEIGHT_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned CW = credit_width(FIFO_DEPTH);

  seq_state_e             r_state;
  seq_state_e             w_state_nxt;
  logic                   w_done_nxt;
  logic                   r_done;
  logic [AWIDTH-1:0]      r_addr_cnt;
  logic [PASS_WIDTH-1:0]  r_pass_cnt;
  logic [PASS_WIDTH-1:0]  r_passes;
  logic [CW-1:0]          r_credits;
  logic [ROM_LATENCY-1:0] r_vld_pipe;
  logic [ROM_LATENCY-1:0] r_last_pipe;
  logic                   r_fresh;

  logic                   w_issue;
  logic                   w_addr_wrap;
  logic                   w_pass_wrap;
  logic                   w_rom_ce;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_fifo_valid;
  logic [CW-1:0]          w_fifo_count;
  logic [DWIDTH:0]        w_fifo_head;

  assign w_accept    = (r_state == IDLE) && start;
  assign w_issue     = (r_state == RUN) && (r_credits != '0);
  assign w_addr_wrap = (r_addr_cnt == AWIDTH'(DEPTH - 1));
  assign w_pass_wrap = (r_pass_cnt == r_passes - PASS_WIDTH'(1));
  assign w_rom_ce    = w_issue | (|r_vld_pipe);
  // fresh marks that the ROM output just advanced, so a held word is pushed once only.
  assign w_push      = r_fresh && r_vld_pipe[ROM_LATENCY-1];
  assign w_pop       = w_fifo_valid && data_out_ready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (cfg_passes == '0) w_done_nxt  = 1'b1;
          else                  w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_issue && w_addr_wrap && w_pass_wrap) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as the final buffered word is taken, so done lands the cycle after that pop.
        if ((r_vld_pipe == '0) &&
            (!w_fifo_valid || ((w_fifo_count == CW'(1)) && w_pop))) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_done      <= 1'b0;
      r_addr_cnt  <= '0;
      r_pass_cnt  <= '0;
      r_passes    <= '0;
      r_credits   <= CW'(FIFO_DEPTH);
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_fresh     <= 1'b0;
    end else begin
      r_done  <= w_done_nxt;
      r_fresh <= w_rom_ce;
      if (w_accept) begin
        r_passes   <= cfg_passes;
        r_addr_cnt <= '0;
        r_pass_cnt <= '0;
      end else if (w_issue) begin
        if (w_addr_wrap) begin
          r_addr_cnt <= '0;
          r_pass_cnt <= w_pass_wrap ? '0 : r_pass_cnt + PASS_WIDTH'(1);
        end else begin
          r_addr_cnt <= r_addr_cnt + AWIDTH'(1);
        end
      end
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
      if (w_rom_ce) begin
        r_vld_pipe  <= ROM_LATENCY'({r_vld_pipe, w_issue});
        r_last_pipe <= ROM_LATENCY'({r_last_pipe, w_issue && w_addr_wrap});
      end
    end
  end

  weight_seq_fifo #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({r_last_pipe[ROM_LATENCY-1], rom_q}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign rom_addr       = r_addr_cnt;
  assign rom_ce         = w_rom_ce;
  assign data_out_valid = w_fifo_valid;
  assign data_out       = w_fifo_valid ? w_fifo_head[DWIDTH-1:0] : '0;
  assign data_out_last  = w_fifo_valid & w_fifo_head[DWIDTH];

`ifdef WEIGHT_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of backpressured cycles for the current job.
  always_ff @(posedge clk) begin
    if (!rst)                                                    r_stall_cnt <= '0;
    else if (w_accept)                                           r_stall_cnt <= '0;
    else if (w_fifo_valid && !data_out_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'(1);
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_weight_stream_sequencer.sv
// Directed bench for weight_stream_sequencer with an 8-word ROM holding its own addresses.
module tb_weight_stream_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_passes;
  logic        busy;
  logic        done;
  logic [3:0]  rom_addr;
  logic        rom_ce;
  logic [15:0] rom_q;
  logic [15:0] data_out;
  logic        data_out_last;
  logic        data_out_valid;
  logic        data_out_ready;
`ifdef WEIGHT_SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_total = 0;
  int n_bad   = 0;

  weight_stream_sequencer #(
    .DWIDTH      (16),
    .DEPTH       (8),
    .ROM_LATENCY (2),
    .FIFO_DEPTH  (4),
    .PASS_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_passes     (cfg_passes),
    .busy           (busy),
    .done           (done),
    .rom_addr       (rom_addr),
    .rom_ce         (rom_ce),
    .rom_q          (rom_q),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage ce-gated ROM: word == address.
  logic [3:0] rom_s1;
  logic [3:0] rom_s2;
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_s1 <= rom_addr;
      rom_s2 <= rom_s1;
    end
  end
  assign rom_q = 16'(rom_s2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int first_pop, last_pop, done_cyc, n_words, n_lasts, ce_0_20, ce_7_20, n_stalls, busy_hi;
  logic [15:0] held_word;

  // Runs one job from cycle 0 (start high); returns in the cycle done is seen or after abort_n words.
  task automatic run_job(input int passes, input int rmode, input int abort_n,
                         input int poke, input bit chk_addr);
    int cyc;
    bit fin;
    first_pop = -1; last_pop = -1; done_cyc = -1; n_words = 0; n_lasts = 0;
    ce_0_20 = 0; ce_7_20 = 0; n_stalls = 0; busy_hi = 0; held_word = 16'hffff;
    cyc = 0;
    fin = 1'b0;
    start = 1'b1;
    cfg_passes = 16'(passes);
    while (!fin && cyc < 400) begin
      case (rmode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = (cyc > 20);
        default: data_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == poke) begin
        start = 1'b1;
        cfg_passes = 16'd5;
      end else if (cyc != 0) begin
        start = 1'b0;
      end
      if (data_out_valid && data_out_ready) begin
        check("word", 32'(data_out), 32'(n_words % 8));
        check("last", 32'(data_out_last), 32'((n_words % 8) == 7));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_words++;
        if (data_out_last) n_lasts++;
      end
      if (data_out_valid && !data_out_ready) n_stalls++;
      if (rom_ce && cyc <= 20) ce_0_20++;
      if (rom_ce && cyc >= 7 && cyc <= 20) ce_7_20++;
      if (busy) busy_hi++;
      if (rmode == 1 && cyc == 20) held_word = data_out_valid ? data_out : 16'hffff;
      if (chk_addr && cyc >= 1 && cyc <= 8 * passes) begin
        check("addr", 32'(rom_addr), 32'((cyc - 1) % 8));
        check("ce", 32'(rom_ce), 32'd1);
      end
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      if (abort_n > 0 && n_words == abort_n) fin = 1'b1;
      if (!fin) begin
        step();
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_ce"},    32'(rom_ce), 32'd0);
    check({tag, "_valid"}, 32'(data_out_valid), 32'd0);
    check({tag, "_last"},  32'(data_out_last), 32'd0);
    check({tag, "_addr"},  32'(rom_addr), 32'd0);
    check({tag, "_data"},  32'(data_out), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    cfg_passes = '0;
    data_out_ready = 1'b0;
    step();
    step();
    check_quiet("reset");
    rst = 1'b1;
    step();

    // 1: single pass, full throughput
    run_job(1, 0, 0, -1, 1'b0);
    check("t1_first", 32'(first_pop), 32'd4);
    check("t1_lastpop", 32'(last_pop), 32'd11);
    check("t1_done", 32'(done_cyc), 32'd12);
    check("t1_words", 32'(n_words), 32'd8);
    check("t1_lasts", 32'(n_lasts), 32'd1);
    step();
    check("t1_done_pulse", 32'(done), 32'd0);
    step();

    // 2: held off by ready=0 through cycle 20
    run_job(1, 1, 0, -1, 1'b0);
    check("t2_ce_0_20", 32'(ce_0_20), 32'd6);
    check("t2_ce_stalled", 32'(ce_7_20), 32'd0);
    check("t2_held", 32'(held_word), 32'd0);
    check("t2_first", 32'(first_pop), 32'd21);
    check("t2_lastpop", 32'(last_pop), 32'd28);
    check("t2_done", 32'(done_cyc), 32'd29);
    check("t2_words", 32'(n_words), 32'd8);
    step();
    step();

    // 3: three passes, address wrap without bubble
    run_job(3, 0, 0, -1, 1'b1);
    check("t3_words", 32'(n_words), 32'd24);
    check("t3_lasts", 32'(n_lasts), 32'd3);
    check("t3_first", 32'(first_pop), 32'd4);
    check("t3_lastpop", 32'(last_pop), 32'd27);
    check("t3_done", 32'(done_cyc), 32'd28);
    step();
    step();

    // 4: zero passes
    run_job(0, 0, 0, -1, 1'b0);
    check("t4_done", 32'(done_cyc), 32'd1);
    check("t4_ce", 32'(ce_0_20), 32'd0);
    check("t4_busy", 32'(busy_hi), 32'd0);
    check("t4_words", 32'(n_words), 32'd0);
    step();
    check("t4_done_pulse", 32'(done), 32'd0);
    step();

    // 5: reset mid-pass after word 3, then a clean restart
    run_job(1, 0, 4, -1, 1'b0);
    check("t5_words", 32'(n_words), 32'd4);
    rst = 1'b0;
    step();
    check_quiet("t5_rst");
    rst = 1'b1;
    step();
    run_job(1, 0, 0, -1, 1'b0);
    check("t5_first", 32'(first_pop), 32'd4);
    check("t5_words2", 32'(n_words), 32'd8);
    check("t5_done", 32'(done_cyc), 32'd12);
    step();
    step();

    // 6: random backpressure, start poked while busy
    run_job(2, 2, 0, 10, 1'b0);
    check("t6_words", 32'(n_words), 32'd16);
    check("t6_lasts", 32'(n_lasts), 32'd2);
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    check("t6_stalls", stall_cycles, 32'(n_stalls));
`endif
    step();
    check("t6_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
